// File: rtl/ahb_lite_mem_slave.sv
// AHB-lite single-port memory slave with byte/half/word access, programmable
// wait states, read-after-write forwarding and the two-cycle ERROR response.
module ahb_lite_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      wait_cnt, cnt_nxt;

  // Data-phase context of the transfer currently being completed.
  logic             dp_valid;
  logic             dp_write;
  logic [IDX_W-1:0] dp_idx;
  logic [3:0]       dp_lanes;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  accept;
  logic                  acc_err;
  logic [IDX_W-1:0]      acc_idx;
  logic [3:0]            acc_lanes;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_word;

  logic unused_ok;
  assign unused_ok = ^{htrans[0], hburst, hprot};

  assign hreadyout = (state == S_IDLE) || (state == S_ERR2);
  assign hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;

  // A new address phase is only taken while this slave is not stalling.
  assign accept  = hsel && hready && htrans[1] && hreadyout;
  assign acc_idx = haddr[IDX_W+1:2];
  assign commit  = dp_valid && dp_write && hreadyout;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    acc_err   = 1'b0;
    acc_lanes = 4'b0000;
    if ((haddr >> 2) >= ADDR_WIDTH'(MEM_DEPTH)) acc_err = 1'b1;
    case (hsize)
      3'd0: acc_lanes = 4'b0001 << haddr[1:0];
      3'd1: begin
        acc_lanes = haddr[1] ? 4'b1100 : 4'b0011;
        if (haddr[0]) acc_err = 1'b1;
      end
      3'd2: begin
        acc_lanes = 4'b1111;
        if (haddr[1:0] != 2'b00) acc_err = 1'b1;
      end
      default: acc_err = 1'b1;
    endcase
  end

  // A read accepted on the edge where a write to the same word commits sees
  // that write's enabled lanes.
  always_comb begin
    rd_word = mem[acc_idx];
    for (int i = 0; i < 4; i++) begin
      if (commit && (dp_idx == acc_idx) && dp_lanes[i]) begin
        rd_word[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    case (state)
      S_IDLE, S_ERR2: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (acc_err) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_nxt = S_IDLE;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_lanes <= '0;
      hrdata   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      if (accept) begin
        dp_valid <= !acc_err;
        dp_write <= hwrite;
        dp_idx   <= acc_idx;
        dp_lanes <= acc_lanes;
        if (!acc_err && !hwrite) hrdata <= rd_word;
      end else if (hreadyout) begin
        dp_valid <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; clearing it would turn the RAM
  // into a flop array, and its contents are undefined after power-up anyway.
  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_lanes[i]) mem[dp_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench: two slaves (0 and 2 wait states) on a shared master bus,
// driven from a pipelined sequencer with a reference-memory scoreboard.
`timescale 1ns/1ps
module tb_ahb_lite_mem_slave;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
    logic [2:0]  burst;
  } xfer_t;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel0 = 1'b0;
  logic        hsel2 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'h3;
  logic [31:0] hwdata = '0;

  logic [31:0] hrdata0, hrdata2;
  logic        hreadyout0, hreadyout2;
  logic [1:0]  hresp0, hresp2;

  always #5 hclk = ~hclk;

  ahb_lite_mem_slave #(.WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hready(hreadyout0), .hwdata(hwdata),
    .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
  );

  ahb_lite_mem_slave #(.WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hready(hreadyout2), .hwdata(hwdata),
    .hrdata(hrdata2), .hreadyout(hreadyout2), .hresp(hresp2)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  xfer_t       stim_q[$];
  exp_t        sb_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [2];

  function automatic logic [3:0] lanes_of(input logic [1:0] a, input logic [2:0] s);
    case (s)
      3'd0:    return 4'b0001 << a;
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic addr_err(input logic [31:0] a, input logic [2:0] s);
    if ((a >> 2) >= 32'd256) return 1'b1;
    if (s > 3'd2) return 1'b1;
    if (s == 3'd1 && a[0]) return 1'b1;
    if (s == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: applies each transfer in bus order and returns what the
  // slave must report when that transfer's data phase completes.
  function automatic exp_t predict(input int which, input xfer_t t, input int ws);
    exp_t        e;
    logic [31:0] w;
    logic [3:0]  ln;
    int          key;
    key     = which * 4096 + int'(t.addr >> 2);
    ln      = lanes_of(t.addr[1:0], t.size);
    e.err   = addr_err(t.addr, t.size);
    e.rd    = !t.wr;
    e.waits = e.err ? 1 : ws;
    e.data  = last_rd[which];
    if (!e.err) begin
      if (t.wr) begin
        w = ref_mem.exists(key) ? ref_mem[key] : 32'hxxxxxxxx;
        for (int i = 0; i < 4; i++) if (ln[i]) w[8*i +: 8] = t.wdata[8*i +: 8];
        ref_mem[key] = w;
      end else begin
        e.data = ref_mem.exists(key) ? ref_mem[key] : 32'hxxxxxxxx;
        last_rd[which] = e.data;
      end
    end
    return e;
  endfunction

  task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [1:0] trans, input logic [2:0] burst);
    xfer_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata; t.trans = trans; t.burst = burst;
    stim_q.push_back(t);
  endtask

  // Pipelined master: presents the next address while the previous transfer's
  // data phase completes, and scores every data-phase cycle.
  task automatic run_queue(input int which, input int ws, input string tag);
    logic        rdy;
    logic        busy = 1'b0;
    logic        nxt_v = 1'b0;
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [31:0] nxt_wdata = '0;
    int          stall = 0;
    int          guard = 0;
    exp_t        e;
    xfer_t       t;
    hsel0 = (which == 0);
    hsel2 = (which == 1);
    while ((stim_q.size() > 0 || busy || nxt_v) && guard < 500) begin
      @(negedge hclk);
      guard++;
      if (nxt_v) begin
        busy   = 1'b1;
        nxt_v  = 1'b0;
        stall  = 0;
        hwdata = nxt_wdata;
      end
      rdy  = (which == 1) ? hreadyout2 : hreadyout0;
      resp = (which == 1) ? hresp2 : hresp0;
      rd   = (which == 1) ? hrdata2 : hrdata0;
      if (busy) begin
        e = sb_q[0];
        if (!rdy) begin
          stall++;
          n_checks++;
          if (resp !== (e.err ? 2'b01 : 2'b00)) begin
            n_fail++;
            $display("FAIL %s stall_hresp: got %b expected %b", tag, resp, e.err ? 2'b01 : 2'b00);
          end
        end else begin
          void'(sb_q.pop_front());
          busy = 1'b0;
          n_checks++;
          if (resp !== (e.err ? 2'b01 : 2'b00)) begin
            n_fail++;
            $display("FAIL %s done_hresp: got %b expected %b", tag, resp, e.err ? 2'b01 : 2'b00);
          end
          n_checks++;
          if (stall !== e.waits) begin
            n_fail++;
            $display("FAIL %s wait_cycles: got %0d expected %0d", tag, stall, e.waits);
          end
          if (e.rd) begin
            n_checks++;
            if (rd !== e.data) begin
              n_fail++;
              $display("FAIL %s hrdata: got %h expected %h", tag, rd, e.data);
            end
          end
        end
      end
      if (rdy && stim_q.size() > 0) begin
        t = stim_q.pop_front();
        haddr  = t.addr;
        hwrite = t.wr;
        hsize  = t.size;
        hburst = t.burst;
        htrans = t.trans;
        sb_q.push_back(predict(which, t, ws));
        nxt_v     = 1'b1;
        nxt_wdata = t.wdata;
      end else begin
        htrans = 2'b00;
      end
    end
    if (guard >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got %0d cycles expected under 500", tag, guard);
      stim_q.delete();
      sb_q.delete();
      htrans = 2'b00;
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    repeat (2) @(negedge hclk);
    n_checks++;
    if ({hreadyout0, hresp0, hrdata0} !== {1'b1, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_dut0: got rdy=%b resp=%b rdata=%h expected 1/00/0", hreadyout0, hresp0, hrdata0);
    end
    n_checks++;
    if ({hreadyout2, hresp2, hrdata2} !== {1'b1, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_dut2: got rdy=%b resp=%b rdata=%h expected 1/00/0", hreadyout2, hresp2, hrdata2);
    end
    hresetn = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic test_word_rw();
    push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 2'b10, 3'd0);
    push(1'b0, 32'h10, 3'd2, 32'h0, 2'b10, 3'd0);
    run_queue(0, 0, "word_rw");
  endtask

  task automatic test_subword();
    push(1'b1, 32'h11, 3'd0, 32'h0000A500, 2'b10, 3'd0);
    push(1'b0, 32'h10, 3'd2, 32'h0, 2'b10, 3'd0);
    push(1'b1, 32'h12, 3'd1, 32'h12340000, 2'b10, 3'd0);
    push(1'b0, 32'h10, 3'd2, 32'h0, 2'b10, 3'd0);
    push(1'b0, 32'h12, 3'd1, 32'h0, 2'b10, 3'd0);
    run_queue(0, 0, "subword");
  endtask

  task automatic test_back_to_back();
    push(1'b1, 32'h20, 3'd2, 32'h55AA55AA, 2'b10, 3'd0);
    push(1'b0, 32'h20, 3'd2, 32'h0, 2'b10, 3'd0);
    push(1'b1, 32'h21, 3'd0, 32'h00007700, 2'b10, 3'd0);
    push(1'b0, 32'h20, 3'd2, 32'h0, 2'b10, 3'd0);
    push(1'b1, 32'h24, 3'd2, 32'h01020304, 2'b10, 3'd0);
    push(1'b0, 32'h20, 3'd2, 32'h0, 2'b10, 3'd0);
    push(1'b0, 32'h24, 3'd2, 32'h0, 2'b10, 3'd0);
    run_queue(0, 0, "back_to_back");
  endtask

  task automatic test_wait_states();
    push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 2'b10, 3'd0);
    push(1'b0, 32'h10, 3'd2, 32'h0, 2'b10, 3'd0);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 32'h30 + 32'(4 * i), 3'd2, 32'hC0DE0000 + 32'(i), (i == 0) ? 2'b10 : 2'b11, 3'd1);
    end
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 32'h30 + 32'(4 * i), 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11, 3'd1);
    end
    run_queue(1, 2, "wait_states");
  endtask

  task automatic test_error();
    push(1'b1, 32'h3FC, 3'd2, 32'hCAFEF00D, 2'b10, 3'd0);
    push(1'b1, 32'h400, 3'd2, 32'hBAD0BAD0, 2'b10, 3'd0);
    push(1'b0, 32'h400, 3'd2, 32'h0, 2'b10, 3'd0);
    push(1'b0, 32'h3FC, 3'd2, 32'h0, 2'b10, 3'd0);
    push(1'b1, 32'h13, 3'd1, 32'hFFFF0000, 2'b10, 3'd0);
    push(1'b0, 32'h12, 3'd3, 32'h0, 2'b10, 3'd0);
    push(1'b0, 32'h10, 3'd2, 32'h0, 2'b10, 3'd0);
    push(1'b0, 32'h3FC, 3'd2, 32'h0, 2'b10, 3'd0);
    run_queue(0, 0, "error_ws0");
    push(1'b1, 32'h400, 3'd2, 32'hBAD0BAD0, 2'b10, 3'd0);
    push(1'b0, 32'h16, 3'd2, 32'h0, 2'b10, 3'd0);
    push(1'b0, 32'h10, 3'd2, 32'h0, 2'b10, 3'd0);
    run_queue(1, 2, "error_ws2");
  endtask

  task automatic test_reset_mid_wait();
    push(1'b1, 32'h40, 3'd2, 32'h11223344, 2'b10, 3'd0);
    run_queue(1, 2, "pre_reset");
    @(negedge hclk);
    hsel0  = 1'b0;
    hsel2  = 1'b1;
    haddr  = 32'h40;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = 2'b10;
    @(negedge hclk);
    htrans = 2'b00;
    hwdata = 32'h99999999;
    n_checks++;
    if (hreadyout2 !== 1'b0) begin
      n_fail++;
      $display("FAIL in_wait_ready: got %b expected 0", hreadyout2);
    end
    #2 hresetn = 1'b0;
    #1;
    n_checks++;
    if ({hreadyout2, hresp2, hrdata2} !== {1'b1, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b resp=%b rdata=%h expected 1/00/0", hreadyout2, hresp2, hrdata2);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    push(1'b0, 32'h40, 3'd2, 32'h0, 2'b10, 3'd0);
    run_queue(1, 2, "post_reset");
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_subword();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid_wait();
    repeat (2) @(negedge hclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
# ahb_lite_mem_slave

AHB-lite single-port memory slave that consumes the master-side transfers driven by the testbench driver (haddr, htrans, hwrite, hsize, hburst, hwdata) and returns hrdata, hreadyout and hresp. It is the DUT that sits directly downstream of the bench's AHB interface. It supports byte, halfword and word accesses, a configurable number of wait states, read-after-write forwarding, and the two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 32, width of haddr
- DATA_WIDTH, 32, width of hwdata/hrdata (only 32 supported)
- MEM_DEPTH, 256, number of 32-bit words
- WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY transfer (0..15)

Ports:
- hclk  in  1  clock, all state on rising edge
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  ADDR_WIDTH  byte address
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1=write
- hsize  in  3  0=byte, 1=half, 2=word
- hburst  in  3  ignored (per-beat addressing)
- hprot  in  4  ignored
- hready  in  1  bus-wide ready (previous transfer complete)
- hwdata  in  DATA_WIDTH  write data, valid in data phase
- hrdata  out  DATA_WIDTH  read data
- hreadyout  out  1  slave ready
- hresp  out  2  OKAY=00, ERROR=01

## Operation
- Accept: at a rising edge with hsel=1, hready=1 and htrans[1]=1, the slave latches addr, write, size and enters the data phase. IDLE, BUSY, hsel=0 or hready=0: nothing latched, zero-wait OKAY.
- Error check at accept: word index haddr>>2 >= MEM_DEPTH, or hsize>2, or misaligned (half with haddr[0]=1, word with haddr[1:0]!=0) -> ERROR transfer; memory not written, hrdata unchanged.
- FSM states: IDLE (hreadyout=1, OKAY); WAIT (hreadyout=0, OKAY, counter down from WAIT_STATES); ERR1 (hreadyout=0, hresp=01); ERR2 (hreadyout=1, hresp=01).
  - IDLE/last cycle of any data phase + good accept -> WAIT if WAIT_STATES>0, else stay in IDLE (completes in 1 cycle).
  - + error accept -> ERR1 -> ERR2 -> IDLE (or next accept at end of ERR2).
  - WAIT with counter reaching 1 -> IDLE (complete) next cycle.
- Write: at the completing edge (hreadyout=1 in data phase), hwdata byte lanes selected little-endian by size/addr[1:0] are written: byte lane addr[1:0]; half lanes {addr[1],0}+0/1; word all four.
- Read: full word returned regardless of size; hrdata loaded at accept edge, held until next read load; valid when hreadyout=1 in a read data phase.
- Forwarding: if a read is accepted at the same edge a write to the same word commits, hrdata = memory word with that write's enabled lanes replaced by hwdata.
- Memory contents not cleared by reset; undefined after power-up.

## Timing
- Reset (async, hresetn=0): state IDLE, hreadyout=1, hresp=00, hrdata=0, counter=0; any pending transfer discarded, no write performed. Release takes effect at the next rising edge.
- Zero-wait OKAY: address sampled edge N, data phase cycle N..N+1 with hreadyout=1; write commits edge N+1; next transfer may be accepted at edge N+1 (pipelined).
- WAIT_STATES=W: hreadyout=0 for W cycles after edge N, 1 in cycle W+1; completes at edge N+W+1.
- ERROR: exactly two data-phase cycles (ERR1, ERR2) regardless of WAIT_STATES.
- Address phase presented while hreadyout=0 is not accepted (hready=0).

## Test plan
- Word write 0xDEADBEEF to 0x10, then read 0x10 -> hrdata=0xDEADBEEF, hresp=00, zero wait.
- Byte write 0xA5 (hwdata=0x0000A500) to 0x11, then read 0x10 -> 0xDEADA5EF; halfword write 0x1234 to 0x12 -> 0x1234A5EF.
- Back-to-back NONSEQ write 0x55AA55AA to 0x20 immediately followed by read 0x20 -> read returns 0x55AA55AA (forwarding).
- WAIT_STATES=2: read 0x10 -> hreadyout low exactly 2 cycles, high in 3rd with correct data; 4-beat INCR write burst -> each beat 3 cycles.
- MEM_DEPTH=256: write to 0x400 -> ERR1 (hreadyout=0, hresp=01) then ERR2 (hreadyout=1, hresp=01); read 0x400 neighbour 0x3FC unchanged; halfword at 0x13 -> same ERROR.
- hresetn asserted mid WAIT of a write -> hreadyout=1, hresp=00, hrdata=0 immediately; target word unchanged on subsequent read.
